// File: rtl/alu_stimulus_sequencer.sv
// Button/switch front end for the ALU demonstrator: synchronises and debounces the
// raw inputs and steps the (operacion, addra, addrb) sequence manually or on a timer.

module alu_stimulus_sequencer_debounce #(
   parameter int CYCLES = 500000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic level_i,
   output logic deb_o
);
   localparam int CW = $clog2(CYCLES);

   logic [CW-1:0] cnt_r;
   logic          deb_r;

   // Accept a new level only after CYCLES consecutive disagreeing samples.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_r <= {CW{1'b0}};
         deb_r <= 1'b0;
      end else if (level_i == deb_r) begin
         cnt_r <= {CW{1'b0}};
      end else if (cnt_r == CW'(CYCLES - 1)) begin
         deb_r <= level_i;
         cnt_r <= {CW{1'b0}};
      end else begin
         cnt_r <= cnt_r + CW'(1);
      end
   end

   assign deb_o = deb_r;
endmodule

module alu_stimulus_sequencer #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int AUTO_PERIOD     = 50000000,
   parameter int OP_LAST         = 7
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       btn_step_i,
   input  logic       btn_mode_i,
   input  logic       auto_en_i,
   output logic [2:0] addra_o,
   output logic [2:0] addrb_o,
   output logic [2:0] operacion_o,
   output logic [1:0] seloperacion_o,
   output logic       step_o,
   output logic       wrap_o,
   output logic       auto_o
);
   localparam int         TW     = $clog2(AUTO_PERIOD);
   localparam logic [2:0] OP_MAX = 3'(OP_LAST);

   typedef enum logic [0:0] {
      ST_MANUAL = 1'b0,
      ST_AUTO   = 1'b1
   } state_t;

   state_t        state_r, state_nxt_s;
   logic [TW-1:0] timer_r, timer_nxt_s;
   logic [2:0]    sync1_r, sync2_r;
   logic          deb_step_s, deb_mode_s;
   logic          deb_step_d_r, deb_mode_d_r;
   logic          step_rise_s, mode_rise_s, auto_tick_s, step_evt_s, wrap_nxt_s;
   logic [2:0]    addra_nxt_s, addrb_nxt_s, op_nxt_s;
   logic [1:0]    sel_nxt_s;

   // Two-flop synchronisers; bit order {auto_en, mode, step}.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_r <= 3'b000;
         sync2_r <= 3'b000;
      end else begin
         sync1_r <= {auto_en_i, btn_mode_i, btn_step_i};
         sync2_r <= sync1_r;
      end
   end

   alu_stimulus_sequencer_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_step (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .level_i (sync2_r[0]),
      .deb_o   (deb_step_s)
   );

   alu_stimulus_sequencer_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_mode (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .level_i (sync2_r[1]),
      .deb_o   (deb_mode_s)
   );

   assign step_rise_s = deb_step_s & ~deb_step_d_r;
   assign mode_rise_s = deb_mode_s & ~deb_mode_d_r;

   // Mode FSM and auto-step timer; a step due on the exit cycle still fires.
   always_comb begin
      state_nxt_s = state_r;
      timer_nxt_s = timer_r;
      auto_tick_s = 1'b0;
      case (state_r)
         ST_MANUAL: begin
            timer_nxt_s = {TW{1'b0}};
            if (sync2_r[2]) begin
               state_nxt_s = ST_AUTO;
            end else begin
               state_nxt_s = ST_MANUAL;
            end
         end
         ST_AUTO: begin
            if (timer_r == TW'(AUTO_PERIOD - 1)) begin
               auto_tick_s = 1'b1;
               timer_nxt_s = {TW{1'b0}};
            end else begin
               timer_nxt_s = timer_r + TW'(1);
            end
            if (!sync2_r[2]) begin
               state_nxt_s = ST_MANUAL;
               timer_nxt_s = {TW{1'b0}};
            end else begin
               state_nxt_s = ST_AUTO;
            end
         end
         default: begin
            state_nxt_s = ST_MANUAL;
            timer_nxt_s = {TW{1'b0}};
         end
      endcase
   end

   assign step_evt_s = auto_tick_s | (step_rise_s & (state_r == ST_MANUAL));

   // Nested counter: addrb is least significant, operacion most significant.
   always_comb begin
      addrb_nxt_s = addrb_o;
      addra_nxt_s = addra_o;
      op_nxt_s    = operacion_o;
      if (step_evt_s) begin
         addrb_nxt_s = addrb_o + 3'd1;
         if (addrb_o == 3'd7) begin
            addra_nxt_s = addra_o + 3'd1;
            if (addra_o == 3'd7) begin
               if (operacion_o == OP_MAX) begin
                  op_nxt_s = 3'd0;
               end else begin
                  op_nxt_s = operacion_o + 3'd1;
               end
            end else begin
               op_nxt_s = operacion_o;
            end
         end else begin
            addra_nxt_s = addra_o;
         end
      end else begin
         addrb_nxt_s = addrb_o;
      end
   end

   assign wrap_nxt_s = step_evt_s & (addrb_nxt_s == 3'd0) & (addra_nxt_s == 3'd0) &
                       (op_nxt_s == 3'd0);

   // Display source rotates result -> A -> B; code 11 falls back to result.
   always_comb begin
      sel_nxt_s = seloperacion_o;
      if (mode_rise_s) begin
         case (seloperacion_o)
            2'b00:   sel_nxt_s = 2'b01;
            2'b01:   sel_nxt_s = 2'b10;
            default: sel_nxt_s = 2'b00;
         endcase
      end else begin
         sel_nxt_s = seloperacion_o;
      end
   end

   // State, edge-detect history and registered outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r        <= ST_MANUAL;
         timer_r        <= {TW{1'b0}};
         deb_step_d_r   <= 1'b0;
         deb_mode_d_r   <= 1'b0;
         addra_o        <= 3'd0;
         addrb_o        <= 3'd0;
         operacion_o    <= 3'd0;
         seloperacion_o <= 2'b00;
         step_o         <= 1'b0;
         wrap_o         <= 1'b0;
         auto_o         <= 1'b0;
      end else begin
         state_r        <= state_nxt_s;
         timer_r        <= timer_nxt_s;
         deb_step_d_r   <= deb_step_s;
         deb_mode_d_r   <= deb_mode_s;
         addra_o        <= addra_nxt_s;
         addrb_o        <= addrb_nxt_s;
         operacion_o    <= op_nxt_s;
         seloperacion_o <= sel_nxt_s;
         step_o         <= step_evt_s;
         wrap_o         <= wrap_nxt_s;
         auto_o         <= (state_nxt_s == ST_AUTO);
      end
   end
endmodule
